// File: rtl/pipelined_csel_add_sub.sv
// Two-stage carry-select add/sub with valid/ready flow control.
// Define ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module pipelined_csel_add_sub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;

  logic             s1_valid_q;
  logic             s2_valid_q;
  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum0_d;
  logic [WIDTH-1:0] sum1_d;
  logic [NBLK-1:0]  c0_d;
  logic [NBLK-1:0]  c1_d;
  logic [WIDTH-1:0] sum0_q;
  logic [WIDTH-1:0] sum1_q;
  logic [NBLK-1:0]  c0_q;
  logic [NBLK-1:0]  c1_q;
  logic             am_q;
  logic             bm_q;

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  assign bx = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLOCK;
    localparam int HI = (LO + BLOCK > WIDTH) ? WIDTH - 1 : LO + BLOCK - 1;
    localparam int BW = HI - LO + 1;

    logic cin_s;
    logic cout_s;

    // Block 0 already knows its carry-in; both slots hold the same result.
    if (k == 0) begin : g_first
      assign {c0_d[k], sum0_d[HI:LO]} =
        {1'b0, in_a[HI:LO]} + {1'b0, bx[HI:LO]} + (BW+1)'(in_sub);
      assign sum1_d[HI:LO] = sum0_d[HI:LO];
      assign c1_d[k]       = c0_d[k];
      assign cin_s         = 1'b0;
    end else begin : g_rest
      assign {c0_d[k], sum0_d[HI:LO]} =
        {1'b0, in_a[HI:LO]} + {1'b0, bx[HI:LO]};
      assign {c1_d[k], sum1_d[HI:LO]} =
        {1'b0, in_a[HI:LO]} + {1'b0, bx[HI:LO]} + (BW+1)'(1);
      assign cin_s = g_blk[k-1].cout_s;
    end

    assign cout_s        = cin_s ? c1_q[k] : c0_q[k];
    assign raw_sum[HI:LO] = cin_s ? sum1_q[HI:LO] : sum0_q[HI:LO];
  end

  assign cout_d = g_blk[NBLK-1].cout_s;
  assign ovf_d  = (am_q == bm_q) && (raw_sum[WIDTH-1] != am_q);

`ifdef ADDSUB_SATURATE_EN
  // Operand sign tells the overflow direction.
  assign sum_d = ovf_d ? {am_q, {(WIDTH-1){~am_q}}} : raw_sum;
`else
  assign sum_d = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      sum0_q     <= '0;
      sum1_q     <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      am_q       <= 1'b0;
      bm_q       <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        sum0_q <= sum0_d;
        sum1_q <= sum1_d;
        c0_q   <= c0_d;
        c1_q   <= c1_d;
        am_q   <= in_a[WIDTH-1];
        bm_q   <= bx[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_pipelined_csel_add_sub.sv
// Randomized bench for pipelined_csel_add_sub against an
// arithmetic reference model and an in-order scoreboard.
module tb_pipelined_csel_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_a, in_b, out_sum;
  logic       in_sub, in_valid, in_ready;
  logic       out_cout, out_ovf, out_valid, out_ready;

  logic [9:0] a10, b10, sum10;
  logic       sub10, v10, rdy10, cout10, ovf10, ov10, ordy10;

  always #5 clk = ~clk;

  pipelined_csel_add_sub #(.WIDTH(8), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipelined_csel_add_sub #(.WIDTH(10), .BLOCK(4)) dut10 (
    .clk(clk), .rst_n(rst_n),
    .in_a(a10), .in_b(b10), .in_sub(sub10),
    .in_valid(v10), .in_ready(rdy10),
    .out_sum(sum10), .out_cout(cout10), .out_ovf(ovf10),
    .out_valid(ov10), .out_ready(ordy10)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pops  = 0;
  int accs  = 0;

  logic [9:0] q[$];
  logic [9:0] s_got;
  logic       s_ov;
  logic       s_ir;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic s);
    int sa, sb, r, u;
    logic c, o;
    logic [7:0] y;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? sa - sb : sa + sb;
    u  = s ? int'(a) - int'(b) : int'(a) + int'(b);
    c  = s ? (a >= b) : (u > 255);
    o  = (r > 127) || (r < -128);
    y  = 8'(u);
`ifdef ADDSUB_SATURATE_EN
    if (r > 127)  y = 8'h7f;
    if (r < -128) y = 8'h80;
`endif
    return {o, c, y};
  endfunction

  task automatic step(input logic v, input logic [7:0] a,
                      input logic [7:0] b, input logic s,
                      input logic ordy);
    logic acc, orr;
    logic [9:0] e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sub    = s;
    out_ready = ordy;
    #1;
    acc   = in_valid && in_ready;
    orr   = out_valid && out_ready;
    s_got = {out_ovf, out_cout, out_sum};
    s_ov  = out_valid;
    s_ir  = in_ready;
    @(posedge clk);
    if (orr) begin
      pops++;
      chk("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_result", 32'(s_got), 32'(e));
      end
    end
    if (acc) begin
      accs++;
      q.push_back(model(a, b, s));
    end
  endtask

  task automatic one_op(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic s,
                        input logic [9:0] exp);
    step(1'b1, a, b, s, 1'b1);
    step(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk({tag, "_early"}, 32'(s_ov), 0);
    step(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk({tag, "_valid"}, 32'(s_ov), 1);
    chk(tag, 32'(s_got), 32'(exp));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk(tag, 32'(q.size()), 0);
  endtask

  initial begin
    logic [9:0] e;
    int p0, a0;
    rst_n = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a10 = '0; b10 = '0; sub10 = 1'b0; v10 = 1'b0; ordy10 = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum",   32'(out_sum), 0);
    chk("rst_cout",  32'(out_cout), 0);
    chk("rst_ovf",   32'(out_ovf), 0);
    chk("rst_inrdy", 32'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 10-bit instance wrap
    @(negedge clk);
    a10 = 10'd1023; b10 = 10'd1; v10 = 1'b1;
    @(negedge clk);
    v10 = 1'b0;
    for (int i = 0; i < 5 && !ov10; i++) @(negedge clk);
    chk("w10_valid", 32'(ov10), 1);
    chk("w10_sum",   32'(sum10), 0);
    chk("w10_cout",  32'(cout10), 1);

`ifdef ADDSUB_SATURATE_EN
    one_op("add_ovf", 8'd100, 8'd100, 1'b0, {1'b1, 1'b0, 8'd127});
    one_op("sub_ovf", 8'd236, 8'd123, 1'b1, {1'b1, 1'b1, 8'd128});
`else
    one_op("add_ovf", 8'd100, 8'd100, 1'b0, {1'b1, 1'b0, 8'd200});
    one_op("sub_ovf", 8'd236, 8'd123, 1'b1, {1'b1, 1'b1, 8'd113});
`endif
    one_op("add_wrap", 8'd255, 8'd255, 1'b0, {1'b0, 1'b1, 8'd254});
    one_op("sub_brw",  8'd180, 8'd190, 1'b1, {1'b0, 1'b0, 8'd246});

    // back-to-back stream
    p0 = pops;
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    step(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    step(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk("stream_cnt", 32'(pops - p0), 8);
    drain("stream_drain");

    // backpressure
    a0 = accs;
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    chk("bp_accepts", 32'(accs - a0), 2);
    chk("bp_inrdy",   32'(s_ir), 0);
    chk("bp_held",    32'(s_ov), 1);
    e = q[0];
    chk("bp_front",   32'(s_got), 32'(e));
    drain("bp_drain");

    // reset with two in flight
    step(1'b1, 8'd7, 8'd9, 1'b0, 1'b0);
    step(1'b1, 8'd3, 8'd4, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pops;
    for (int i = 0; i < 4; i++)
      step(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
    chk("no_stale", 32'(pops - p0), 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) != 0));
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
